// File: rtl/tournament_predictor_gen2.sv
// Tournament branch predictor: local (LHT + local PHT) vs global (gshare PHT), chosen by a per-PC selector.
// Build option PRED_SPEC_GHR_EN: speculative global history update at lookup, repaired on mispredict.
module tournament_predictor_gen2 #(
  parameter int XLEN           = 32,
  parameter int LHT_IDX_BITS   = 8,
  parameter int LOCAL_HIST_LEN = 8,
  parameter int GHIST_LEN      = 8,
  parameter int SEL_IDX_BITS   = 8,
  parameter int CTR_BITS       = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 ready,
  input  logic                 pred_valid,
  input  logic [XLEN-1:0]      pred_PC,
  output logic                 pred_taken,
  output logic                 pred_local_taken,
  output logic                 pred_global_taken,
  output logic [GHIST_LEN-1:0] pred_ghist,
  input  logic                 res_valid,
  input  logic [XLEN-1:0]      res_PC,
  input  logic                 res_taken,
  input  logic                 res_local_taken,
  input  logic                 res_global_taken,
  input  logic [GHIST_LEN-1:0] res_ghist,
  input  logic                 res_mispredict
);

  localparam int LHT_SIZE  = 1 << LHT_IDX_BITS;
  localparam int LPHT_SIZE = 1 << LOCAL_HIST_LEN;
  localparam int GPHT_SIZE = 1 << GHIST_LEN;
  localparam int SEL_SIZE  = 1 << SEL_IDX_BITS;
  localparam int MAX_AB    = (LHT_IDX_BITS > LOCAL_HIST_LEN) ? LHT_IDX_BITS : LOCAL_HIST_LEN;
  localparam int MAX_CD    = (GHIST_LEN > SEL_IDX_BITS) ? GHIST_LEN : SEL_IDX_BITS;
  localparam int INIT_BITS = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;

  localparam logic [INIT_BITS-1:0] INIT_LAST = {INIT_BITS{1'b1}};
  localparam logic [INIT_BITS-1:0] INIT_ONE  = INIT_BITS'(1);
  localparam logic [CTR_BITS-1:0]  CTR_ZERO  = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0]  CTR_MAX   = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]  CTR_ONE   = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0]  CTR_WEAK  = CTR_ONE << (CTR_BITS - 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  function automatic logic [CTR_BITS-1:0] ctr_update(input logic [CTR_BITS-1:0] c, input logic up);
    logic [CTR_BITS-1:0] r;
    r = c;
    if (up) begin
      if (c != CTR_MAX) r = c + CTR_ONE;
      else              r = c;
    end else begin
      if (c != CTR_ZERO) r = c - CTR_ONE;
      else               r = c;
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [INIT_BITS-1:0]  init_cnt_q, init_cnt_d;
  logic [GHIST_LEN-1:0]  ghr_q, ghr_d;
  logic                  ready_s, init_we_s, upd_en_s;

  logic [LOCAL_HIST_LEN-1:0] lht_q  [LHT_SIZE];
  logic [CTR_BITS-1:0]       lpht_q [LPHT_SIZE];
  logic [CTR_BITS-1:0]       gpht_q [GPHT_SIZE];
  logic [CTR_BITS-1:0]       sel_q  [SEL_SIZE];

  // State and init-index registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= {INIT_BITS{1'b0}};
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: sweep every table index once, then run
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + INIT_ONE;
        if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
        else                         state_d = ST_INIT;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready_s   = 1'b0;
    init_we_s = 1'b0;
    case (state_q)
      ST_INIT: init_we_s = 1'b1;
      ST_RUN:  ready_s   = 1'b1;
      default: begin
        ready_s   = 1'b0;
        init_we_s = 1'b0;
      end
    endcase
  end

  assign ready    = ready_s;
  assign upd_en_s = ready_s & res_valid;

  // Lookup path
  logic [LOCAL_HIST_LEN-1:0] pred_hist_s;
  logic [GHIST_LEN-1:0]      pred_gidx_s;
  logic                      lk_local_s, lk_global_s, lk_sel_local_s;

  assign pred_hist_s    = lht_q[pred_PC[LHT_IDX_BITS+1:2]];
  assign pred_gidx_s    = ghr_q ^ pred_PC[GHIST_LEN+1:2];
  assign lk_local_s     = lpht_q[pred_hist_s][CTR_BITS-1];
  assign lk_global_s    = gpht_q[pred_gidx_s][CTR_BITS-1];
  assign lk_sel_local_s = sel_q[pred_PC[SEL_IDX_BITS+1:2]][CTR_BITS-1];
  assign pred_ghist     = ghr_q;

  // Prediction outputs, forced low until the tables are initialised
  always_comb begin
    pred_taken        = 1'b0;
    pred_local_taken  = 1'b0;
    pred_global_taken = 1'b0;
    if (ready_s) begin
      pred_local_taken  = lk_local_s;
      pred_global_taken = lk_global_s;
      pred_taken        = lk_sel_local_s ? lk_local_s : lk_global_s;
    end else begin
      pred_taken        = 1'b0;
      pred_local_taken  = 1'b0;
      pred_global_taken = 1'b0;
    end
  end

  // Update path
  logic [LHT_IDX_BITS-1:0]   res_lidx_s;
  logic [SEL_IDX_BITS-1:0]   res_sidx_s;
  logic [LOCAL_HIST_LEN-1:0] res_hist_s;
  logic [GHIST_LEN-1:0]      res_gidx_s;

  assign res_lidx_s = res_PC[LHT_IDX_BITS+1:2];
  assign res_sidx_s = res_PC[SEL_IDX_BITS+1:2];
  assign res_hist_s = lht_q[res_lidx_s];
  assign res_gidx_s = res_ghist ^ res_PC[GHIST_LEN+1:2];

  logic                      lht_we_s, lpht_we_s, gpht_we_s, sel_we_s;
  logic [LHT_IDX_BITS-1:0]   lht_widx_s;
  logic [LOCAL_HIST_LEN-1:0] lpht_widx_s, lht_wdata_s;
  logic [GHIST_LEN-1:0]      gpht_widx_s;
  logic [SEL_IDX_BITS-1:0]   sel_widx_s;
  logic [CTR_BITS-1:0]       lpht_wdata_s, gpht_wdata_s, sel_wdata_s;

  // Table write ports; init indices past a table's depth are dropped
  always_comb begin
    lht_we_s     = 1'b0;
    lht_widx_s   = res_lidx_s;
    lht_wdata_s  = {LOCAL_HIST_LEN{1'b0}};
    lpht_we_s    = 1'b0;
    lpht_widx_s  = res_hist_s;
    lpht_wdata_s = CTR_WEAK;
    gpht_we_s    = 1'b0;
    gpht_widx_s  = res_gidx_s;
    gpht_wdata_s = CTR_WEAK;
    sel_we_s     = 1'b0;
    sel_widx_s   = res_sidx_s;
    sel_wdata_s  = CTR_WEAK;
    if (init_we_s) begin
      lht_we_s    = (init_cnt_q >> LHT_IDX_BITS) == {INIT_BITS{1'b0}};
      lht_widx_s  = init_cnt_q[LHT_IDX_BITS-1:0];
      lpht_we_s   = (init_cnt_q >> LOCAL_HIST_LEN) == {INIT_BITS{1'b0}};
      lpht_widx_s = init_cnt_q[LOCAL_HIST_LEN-1:0];
      gpht_we_s   = (init_cnt_q >> GHIST_LEN) == {INIT_BITS{1'b0}};
      gpht_widx_s = init_cnt_q[GHIST_LEN-1:0];
      sel_we_s    = (init_cnt_q >> SEL_IDX_BITS) == {INIT_BITS{1'b0}};
      sel_widx_s  = init_cnt_q[SEL_IDX_BITS-1:0];
    end else if (upd_en_s) begin
      lht_we_s     = 1'b1;
      lht_wdata_s  = {res_hist_s[LOCAL_HIST_LEN-2:0], res_taken};
      lpht_we_s    = 1'b1;
      lpht_wdata_s = ctr_update(lpht_q[res_hist_s], res_taken);
      gpht_we_s    = 1'b1;
      gpht_wdata_s = ctr_update(gpht_q[res_gidx_s], res_taken);
      sel_we_s     = res_local_taken != res_global_taken;
      sel_wdata_s  = ctr_update(sel_q[res_sidx_s], res_local_taken == res_taken);
    end else begin
      lht_we_s  = 1'b0;
      lpht_we_s = 1'b0;
      gpht_we_s = 1'b0;
      sel_we_s  = 1'b0;
    end
  end

  // Table storage; contents are rebuilt by INIT after every reset
  always_ff @(posedge clock) begin
    if (lht_we_s)  lht_q[lht_widx_s]   <= lht_wdata_s;
    if (lpht_we_s) lpht_q[lpht_widx_s] <= lpht_wdata_s;
    if (gpht_we_s) gpht_q[gpht_widx_s] <= gpht_wdata_s;
    if (sel_we_s)  sel_q[sel_widx_s]   <= sel_wdata_s;
  end

  // Global history next value; a mispredict repair beats a same-cycle lookup
  always_comb begin
    ghr_d = ghr_q;
`ifdef PRED_SPEC_GHR_EN
    if (upd_en_s && res_mispredict)  ghr_d = {res_ghist[GHIST_LEN-2:0], res_taken};
    else if (ready_s && pred_valid)  ghr_d = {ghr_q[GHIST_LEN-2:0], pred_taken};
    else                             ghr_d = ghr_q;
`else
    if (upd_en_s) ghr_d = {ghr_q[GHIST_LEN-2:0], res_taken};
    else          ghr_d = ghr_q;
`endif
  end

  // Global history register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ghr_q <= {GHIST_LEN{1'b0}};
    else        ghr_q <= ghr_d;
  end

  logic unused_s;
  assign unused_s = ^{pred_PC, res_PC, pred_valid, res_mispredict};

endmodule

// File: doc/tournament_predictor_gen2.md
TOURNAMENT_PREDICTOR_GEN2 -- requirements
Module: tournament_predictor_gen2

Interface
REQ-001 SHALL have parameter LHT_IDX_BITS, default 8, local history table index width (index = PC[LHT_IDX_BITS+1:2]).
REQ-002 SHALL have parameter LOCAL_HIST_LEN, default 8, per-branch local history width and local PHT index width.
REQ-003 SHALL have parameter GHIST_LEN, default 8, global history width and global PHT index width.
REQ-004 SHALL have parameter SEL_IDX_BITS, default 8, selector table index width (index = PC[SEL_IDX_BITS+1:2]).
REQ-005 SHALL have parameter CTR_BITS, default 2, width of every saturating counter.
REQ-006 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port ready, output, 1, high when table initialisation is complete.
REQ-009 SHALL have port pred_valid, input, 1, a conditional-branch lookup is issued this cycle.
REQ-010 SHALL have port pred_PC, input, XLEN, PC of the branch being predicted.
REQ-011 SHALL have ports pred_taken, pred_local_taken and pred_global_taken, output, 1 each: final, local and global predictions.
REQ-012 SHALL have port pred_ghist, output, GHIST_LEN, global history used for this lookup.
REQ-013 SHALL have ports res_valid (input, 1), res_PC (input, XLEN), res_taken (input, 1), res_local_taken (input, 1), res_global_taken (input, 1), res_ghist (input, GHIST_LEN) and res_mispredict (input, 1), carrying a resolved conditional branch and its lookup metadata.

Function
REQ-014 Lookup SHALL be combinational from pred_PC and current state; all prediction outputs SHALL be 0 while ready is 0.
REQ-015 The local prediction SHALL be the MSB of local PHT[LHT[pred_PC[LHT_IDX_BITS+1:2]]].
REQ-016 The global prediction SHALL be the MSB of global PHT[ghr ^ pred_PC[GHIST_LEN+1:2]].
REQ-017 pred_taken SHALL be the local prediction if the selector counter MSB is 1, else the global prediction.
REQ-018 On res_valid with ready=1, the LHT entry SHALL shift left with res_taken entering at the LSB.
REQ-019 On the same update, the local PHT counter at the pre-shift history SHALL be incremented if res_taken=1, else decremented.
REQ-020 On the same update, the global PHT counter at res_ghist ^ res_PC[GHIST_LEN+1:2] SHALL be incremented if res_taken=1, else decremented.
REQ-021 The selector counter SHALL change only when res_local_taken != res_global_taken: incremented if res_local_taken == res_taken, else decremented.
REQ-022 All counters SHALL saturate at 0 and 2^CTR_BITS-1; a counter SHALL never wrap.
REQ-023 A lookup and an update of the same entry in one cycle SHALL return the old value; the update SHALL be visible from the next cycle.
REQ-024 The FSM SHALL have states INIT and RUN; INIT SHALL write one index per cycle, 0 to D-1, where D = 2^max(LHT_IDX_BITS, LOCAL_HIST_LEN, GHIST_LEN, SEL_IDX_BITS).
REQ-025 INIT SHALL clear LHT entries to 0 and set all counters to 2^(CTR_BITS-1) (weakly taken / weakly local); writes to indices beyond a table's size SHALL be dropped.
REQ-026 The FSM SHALL move to RUN after index D-1, so ready is 1 exactly D cycles after reset release.
REQ-027 pred_valid and res_valid SHALL be ignored in INIT.

Reset
REQ-028 Asserting reset SHALL immediately clear ghr, set the state to INIT, clear the init counter and drive ready=0, including mid-INIT or mid-RUN; table contents are rebuilt by INIT.

Configuration
REQ-029 With PRED_SPEC_GHR_EN defined: on pred_valid in RUN, ghr SHALL become {ghr[GHIST_LEN-2:0], pred_taken}; on res_valid with res_mispredict, ghr SHALL become {res_ghist[GHIST_LEN-2:0], res_taken}, and this SHALL override a same-cycle pred_valid.
REQ-030 Without PRED_SPEC_GHR_EN: ghr SHALL change only on res_valid, to {ghr[GHIST_LEN-2:0], res_taken}; pred_valid and res_mispredict SHALL not affect ghr.
REQ-031 In both modes, pred_ghist SHALL equal ghr.

Verification
REQ-032 Release reset -> ready=0 for 256 cycles, then 1; lookup PC 0x100 -> pred_taken=1, pred_local_taken=1, pred_global_taken=1.
REQ-033 Two resolves at PC 0x40, res_taken=0, res_ghist=0 -> local PHT[0] and global PHT[0x10] both go 10->01->00; lookup PC 0x40 with ghr=0 -> all predictions 0.
REQ-034 Five resolves at PC 0x40, res_taken=1, res_ghist=0 -> global PHT[0x10] reaches 11 and stays 11 (no wrap).
REQ-035 Two resolves at PC 0x80, res_local_taken=1, res_global_taken=0, res_taken=0 -> selector 10->01->00; next lookup at 0x80 returns the global prediction.
REQ-036 With PRED_SPEC_GHR_EN: three taken-predicted lookups -> pred_ghist=0x07; then res_mispredict with res_ghist=0x01, res_taken=0 and a same-cycle pred_valid -> pred_ghist=0x02 next cycle.
REQ-037 Assert reset at INIT cycle 100, release -> ready stays 0 for a full 256 cycles after release.
